// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture and stream blocks.
// State encodings, stream width and the sample extension helper.
package adc_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_WAIT  = ST_WAIT
    } adc_state_t;

    // raw holds the sample in its low `width` bits (1..32); the rest is ignored.
    function automatic logic [AXIS_DATA_WIDTH-1:0] adc_extend(
        input logic [AXIS_DATA_WIDTH-1:0] raw,
        input int unsigned                width,
        input logic                       sign_ext
    );
        logic [AXIS_DATA_WIDTH-1:0] mask;
        logic                       msb;
        mask = (width >= AXIS_DATA_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
        msb  = |(raw & (32'd1 << (width - 1)));
        return (raw & mask) | ((sign_ext && msb) ? ~mask : '0);
    endfunction

endpackage

// File: rtl/adc_spi_shift.sv
// Serial read engine: SCK generation and MSB-first sampling of sdo.
// The sck register doubles as the phase flag of the current bit.
module adc_spi_shift
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned SCK_HALF   = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  sdo,
    output logic                  done,
    output logic                  sck,
    output logic [DATA_WIDTH-1:0] sample
);

    localparam int unsigned HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [HW-1:0] HALF_END = HW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(DATA_WIDTH - 1);

    logic                  r_active;
    logic                  r_sck;
    logic [HW-1:0]         r_half;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;

    logic                  w_half_end;
    logic                  w_bit_end;
    logic [DATA_WIDTH:0]   w_cat;

    assign w_half_end = (r_half == HALF_END);
    assign w_bit_end  = (r_bit == BIT_END);
    assign w_cat      = {r_shift, sdo};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_half   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_sck    <= 1'b1;
            r_half   <= '0;
            r_bit    <= '0;
        end else if (r_active) begin
            if (!w_half_end) begin
                r_half <= r_half + HW'(1);
            end else begin
                r_half <= '0;
                if (r_sck) begin
                    // last cycle of the high phase: capture the bit
                    r_sck   <= 1'b0;
                    r_shift <= w_cat[DATA_WIDTH-1:0];
                end else if (w_bit_end) begin
                    r_active <= 1'b0;
                end else begin
                    r_sck <= 1'b1;
                    r_bit <= r_bit + BW'(1);
                end
            end
        end
    end

    assign done   = r_active && !r_sck && w_half_end && w_bit_end;
    assign sck    = r_sck;
    assign sample = r_shift;

endmodule

// File: rtl/adc_spi_capture.sv
// ADC capture stage: serial read on trigger, one AXI4-Stream beat per sample.
// Owns the acquisition FSM, output register, packet counter and status flags.
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned SCK_HALF   = 1,
    parameter int unsigned PACKET_LEN = 1024,
    parameter int unsigned SIGN_EXT   = 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       trigger,
    output logic                       ready,
    output logic                       last,
    output logic                       overrun,
    output logic                       sck,
    input  logic                       sdo,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);

    localparam int unsigned CNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_LEN - 1);

    adc_state_t                 r_state;
    adc_state_t                 w_next;
    logic                       r_ready;
    logic                       r_last;
    logic                       r_overrun;
    logic                       r_tvalid;
    logic                       r_tlast;
    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic [CNT_W-1:0]           r_cnt;

    logic                       w_start;
    logic                       w_load;
    logic                       w_done;
    logic                       w_hs;
    logic                       w_out_free;
    logic [DATA_WIDTH-1:0]      w_sample;
    logic [AXIS_DATA_WIDTH-1:0] w_ext;
    logic [CNT_W-1:0]           w_cnt_eff;
    logic                       w_tlast_new;

    adc_spi_shift #(
        .DATA_WIDTH(DATA_WIDTH),
        .SCK_HALF  (SCK_HALF)
    ) u_shift (
        .aclk   (aclk),
        .aresetn(aresetn),
        .start  (w_start),
        .sdo    (sdo),
        .done   (w_done),
        .sck    (sck),
        .sample (w_sample)
    );

    assign w_hs       = r_tvalid && m_axis_tready;
    assign w_out_free = !r_tvalid || m_axis_tready;
    assign w_ext      = adc_extend(AXIS_DATA_WIDTH'(w_sample), DATA_WIDTH,
                                   SIGN_EXT != 0);

    // index of the beat being loaded, accounting for a same-cycle handshake
    assign w_cnt_eff   = w_hs ? (r_tlast ? '0 : r_cnt + CNT_W'(1)) : r_cnt;
    assign w_tlast_new = (w_cnt_eff == LAST_IDX);

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_load  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_ready && trigger) begin
                    w_next  = S_SHIFT;
                    w_start = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_done) begin
                    if (w_out_free) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_out_free) begin
                    w_load = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == S_IDLE);
            r_last    <= w_hs && r_tlast;
            r_overrun <= r_overrun || (trigger && !r_ready);
            r_cnt     <= w_cnt_eff;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_tlast_new;
            r_tdata  <= w_ext;
        end else if (w_hs) begin
            r_tvalid <= 1'b0;
        end
    end

    assign ready         = r_ready;
    assign last          = r_last;
    assign overrun       = r_overrun;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
Capture stage directly downstream of the ADC conversion/acquisition trigger block.
- On each acquisition `trigger` pulse it clocks one sample serially out of the ADC (SCK/SDO, MSB first).
- It presents the sample as an AXI4-Stream beat toward the DMA.
- It returns `ready` and `last` to the trigger block: `ready` gates new acquisitions; `last` marks completion of a DMA packet.

Parameters:
DATA_WIDTH, 18, ADC sample bits shifted per acquisition (1..32).
SCK_HALF, 1, aclk cycles per SCK half-period (>=1).
PACKET_LEN, 1024, stream beats per packet; tlast on beat PACKET_LEN-1 (>=1).
SIGN_EXT, 1, 1: sign-extend the sample to 32 bits; 0: zero-extend.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset, asynchronous, active-low.
trigger  in  1  one-cycle acquisition request from the trigger block.
ready  out  1  high when a trigger will be accepted.
last  out  1  one-cycle pulse on the tlast beat handshake.
overrun  out  1  sticky; a trigger arrived while ready was low.
sck  out  1  serial clock to the ADC; idles low.
sdo  in  1  serial data from the ADC; already synchronised to aclk.
m_axis_tdata  out  32  extended sample.
m_axis_tvalid  out  1  AXI4-Stream valid.
m_axis_tready  in  1  AXI4-Stream ready.
m_axis_tlast  out  1  end of packet.

Behaviour:
- Reset (asynchronous, all registers) gives these values:
  - sck=0, ready=0, last=0, overrun=0.
  - tvalid=0, tlast=0, tdata=0.
  - State IDLE; beat counter 0; shift register 0.
- ready rises in the first cycle after reset release.
- Reset mid-shift aborts the transfer. The partial sample is discarded and never emitted.
- States and transitions:
  - IDLE: ready=1. If trigger=1, go to SHIFT next cycle: bit counter=0, half counter=0, ready=0.
  - SHIFT: each bit lasts 2*SCK_HALF cycles. sck=1 for the first SCK_HALF cycles and 0 for the second SCK_HALF cycles.
    - sdo is sampled into the shift register LSB (shift left) in the last aclk cycle of each high phase.
    - At the end of the low phase of bit DATA_WIDTH-1:
      - If the output register is empty, or tvalid&&tready in this cycle: load the output register and go to IDLE.
      - Otherwise go to WAIT.
  - WAIT: sck=0, ready=0. Load the output and go to IDLE in the first cycle where the output register is empty or is being accepted.
- Latency: trigger at cycle T gives sck high in T+1 and tvalid high in T+1+2*SCK_HALF*DATA_WIDTH (T+37 with defaults). ready is high again in that same cycle.
- Output register:
  - Holds tdata/tlast stable while tvalid&&!tready.
  - tvalid clears after a handshake unless a new load happens in the same cycle; then it stays 1 with the new data.
- Extension: tdata[DATA_WIDTH-1:0]=sample. The upper bits are copies of sample[DATA_WIDTH-1] when SIGN_EXT=1, else 0. If DATA_WIDTH=32, no extension.
- Beat counter (width clog2(PACKET_LEN), min 1):
  - Increments on each tvalid&&tready handshake.
  - tlast=1 on the loaded beat when counter==PACKET_LEN-1.
  - Wraps to 0 after the tlast handshake.
  - PACKET_LEN=1: every beat has tlast.
- last: registered; one-cycle pulse in the cycle after the tlast handshake.
- Triggers while ready=0 are ignored and set overrun=1. overrun clears only on reset.
- A trigger in the IDLE cycle where a load completes is accepted normally.
- sck never glitches: it is driven from a register only.

Decomposition:
- Shared package adc_pkg holds:
  - State encodings IDLE/SHIFT/WAIT (2-bit localparams).
  - AXIS_DATA_WIDTH=32.
  - The sign/zero-extension function, shared with other ADC stream blocks.
- One sub-module, adc_spi_shift: SCK generation, half/bit counters, sdo sampling. Interface: start, done, sample[DATA_WIDTH-1:0], sck, sdo.
- The top level owns the FSM, the output register, the beat counter, last and overrun.

Test Plan:
- Single sample (defaults): trigger at T with the ADC model driving 18'h2ABCD MSB-first and tready=1 -> 18 sck pulses, 2 cycles per bit; tvalid at T+37 with tdata=32'hFFFEABCD (sign-extended); ready high at T+37.
- SIGN_EXT=0, DATA_WIDTH=16, sdo pattern 16'h8001 -> tdata=32'h00008001.
- Back-pressure: tready=0 for 60 cycles with two triggers issued when ready allows -> the second sample waits in WAIT with ready=0; no data loss; both beats are emitted in order once tready=1.
- Packet boundary: PACKET_LEN=4, 9 samples -> tlast on beats 3 and 7; last pulses one cycle after each; the counter wraps.
- Overrun: trigger during SHIFT -> the trigger is ignored; overrun=1 and stays 1; the in-flight sample is still emitted correctly.
- Reset mid-shift: assert aresetn=0 at bit 7 -> sck=0, tvalid=0 immediately; after release, ready=1 and no beat from the aborted sample appears.
